// File: rtl/dz_pkg.sv
// Shared types and constants for the countdown sequencer.
// The sequencer drives the digit select of the dot-matrix display driver.
package dz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } dz_state_e;

  localparam int DZ_NUM_W = 3;
  localparam logic [DZ_NUM_W-1:0] DZ_BLANK = 3'd0;

endpackage

// File: rtl/dz_countdown_ctrl_if.sv
// Control/status bundle between the input debouncers, the countdown sequencer
// and the display driver; master drives requests, slave is the sequencer.
interface dz_countdown_ctrl_if;
  import dz_pkg::*;

  logic                start;
  logic                pause;
  logic                abort;
  logic [DZ_NUM_W-1:0] num;
  logic                busy;
  logic                step;
  logic                done;

  modport master (output start, pause, abort, input num, busy, step, done);
  modport slave  (input start, pause, abort, output num, busy, step, done);

endinterface

// File: rtl/dz_countdown_ctrl_tick_counter.sv
// Modulo-N counter with clear priority over enable and a terminal-count flag.
// Wraps by comparing against N-1, never by natural overflow.
module dz_tick_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear wins, then wrap at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/dz_countdown_ctrl.sv
// Countdown sequencer: START_NUM..1, one digit per step period, then blank and
// pulse done. Pause freezes the step timer and blinks the digit; abort returns idle.
module dz_countdown_ctrl
  import dz_pkg::*;
#(
  parameter int TICKS_PER_STEP = 1000,
  parameter int START_NUM      = 4,
  parameter int BLINK_TICKS    = 250
) (
  input  logic                clk,
  input  logic                rst,
  dz_countdown_ctrl_if.slave  ctrl_if
);

  localparam int TICK_W  = $clog2(TICKS_PER_STEP);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [DZ_NUM_W-1:0] START_CODE = DZ_NUM_W'(START_NUM);
  localparam logic [DZ_NUM_W-1:0] LAST_CODE  = 3'd1;

  dz_state_e           state_q, state_d;
  logic [DZ_NUM_W-1:0] cur_q, cur_d;
  logic [DZ_NUM_W-1:0] num_q, num_d;
  logic                start_q;
  logic                busy_q, busy_d;
  logic                step_q, step_d;
  logic                done_q, done_d;
  logic                blink_off_q, blink_off_d;

  logic start_edge;
  logic tick_en, tick_clr, tick_tc;
  logic blink_en, blink_clr, blink_tc;

  assign start_edge = ctrl_if.start & ~start_q;

  dz_tick_counter #(.N(TICKS_PER_STEP), .W(TICK_W)) u_step_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tick_en),
    .clr_i (tick_clr),
    .tc_o  (tick_tc)
  );

  dz_tick_counter #(.N(BLINK_TICKS), .W(BLINK_W)) u_blink_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (blink_en),
    .clr_i (blink_clr),
    .tc_o  (blink_tc)
  );

  // next state; the PAUSE->RUN edge already counts as run time
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    tick_en     = 1'b0;
    tick_clr    = 1'b0;
    blink_en    = 1'b0;
    blink_clr   = 1'b1;
    blink_off_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ctrl_if.abort && start_edge) begin
          state_d  = RUN;
          cur_d    = START_CODE;
          tick_clr = 1'b1;
        end else begin
          state_d = IDLE;
          cur_d   = DZ_BLANK;
        end
      end
      RUN, PAUSE: begin
        if (ctrl_if.abort) begin
          state_d  = IDLE;
          cur_d    = DZ_BLANK;
          tick_clr = 1'b1;
        end else if (ctrl_if.pause) begin
          state_d = PAUSE;
          if (state_q == PAUSE) begin
            blink_en    = 1'b1;
            blink_clr   = 1'b0;
            blink_off_d = blink_tc ? ~blink_off_q : blink_off_q;
          end else begin
            blink_off_d = 1'b0;
          end
        end else begin
          state_d = RUN;
          tick_en = 1'b1;
          if (!tick_tc) begin
            cur_d = cur_q;
          end else if (cur_q > LAST_CODE) begin
            cur_d  = cur_q - 3'd1;
            step_d = 1'b1;
          end else begin
            state_d = IDLE;
            cur_d   = DZ_BLANK;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cur_d   = DZ_BLANK;
      end
    endcase
    num_d  = (state_d == PAUSE && blink_off_d) ? DZ_BLANK : cur_d;
    busy_d = (state_d != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= DZ_BLANK;
      num_q       <= DZ_BLANK;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      blink_off_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      num_q       <= num_d;
      start_q     <= ctrl_if.start;
      busy_q      <= busy_d;
      step_q      <= step_d;
      done_q      <= done_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign ctrl_if.num  = num_q;
  assign ctrl_if.busy = busy_q;
  assign ctrl_if.step = step_q;
  assign ctrl_if.done = done_q;

endmodule
